// File: rtl/opamp_trim_pkg.sv
// Shared definitions for the op-amp trim SAR controller: state encoding and default sizing.
package opamp_trim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    localparam int DEF_DAC_BITS   = 8;
    localparam int DEF_SETTLE_CYC = 16;

    // Settle counter is sized for the largest legal SETTLE_CYC (255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/opamp_trim_sar_sync2.sv
// Two-flop synchronizer for the asynchronous comparator output.
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/opamp_trim_sar.sv
// Successive-approximation trim controller for a precision op-amp offset DAC, MSB first.
// Every output is a register loaded from next-state values so it lines up with the state it belongs to.
module opamp_trim_sar
    import opamp_trim_pkg::*;
#(
    parameter int DAC_BITS   = DEF_DAC_BITS,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                START,
    input  logic                ABORT,
    input  logic                CMP,
    output logic [DAC_BITS-1:0] DAC_CODE,
    output logic                DAC_LOAD,
    output logic                BUSY,
    output logic                DONE,
    output logic [DAC_BITS-1:0] TRIM,
    output logic                VALID,
    output logic                SATURATED
);

    localparam int                  IDX_W       = (DAC_BITS > 1) ? $clog2(DAC_BITS) : 1;
    localparam logic [DAC_BITS-1:0] MIDSCALE    = {1'b1, {(DAC_BITS-1){1'b0}}};
    localparam logic [DAC_BITS-1:0] ONE         = {{(DAC_BITS-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]    TOP_IDX     = IDX_W'(DAC_BITS - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_e              state_q, state_d;
    logic [DAC_BITS-1:0] work_q, work_d;
    logic [IDX_W-1:0]    bitIdx_q, bitIdx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                restorePend_q, restorePend_d;
    logic [DAC_BITS-1:0] dacCode_q, dacCode_d;
    logic                dacLoad_q, dacLoad_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DAC_BITS-1:0] trim_q, trim_d;
    logic                valid_q, valid_d;
    logic                sat_q, sat_d;

    logic                cmpSync;
    logic [DAC_BITS-1:0] trialMask;
    logic [DAC_BITS-1:0] nextMask;
    logic [DAC_BITS-1:0] keptWork;

    sync2 u_cmpSync (
        .clk_i  (CLK),
        .rst_ni (RESET_N),
        .d_i    (CMP),
        .q_o    (cmpSync)
    );

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        bitIdx_d      = bitIdx_q;
        cnt_d         = cnt_q;
        restorePend_d = restorePend_q;
        dacCode_d     = dacCode_q;
        dacLoad_d     = 1'b0;
        done_d        = 1'b0;
        trim_d        = trim_q;
        valid_d       = valid_q;
        sat_d         = sat_q;

        trialMask = ONE << bitIdx_q;
        nextMask  = ONE << (bitIdx_q - 1'b1);
        keptWork  = cmpSync ? (work_q | trialMask) : work_q;

        unique case (state_q)
            ST_IDLE: begin
                // A fresh search supersedes any restore pulse still owed from an abort.
                if (START && !ABORT) begin
                    state_d       = ST_LOAD;
                    bitIdx_d      = TOP_IDX;
                    work_d        = '0;
                    dacCode_d     = MIDSCALE;
                    dacLoad_d     = 1'b1;
                    restorePend_d = 1'b0;
                end else if (restorePend_q) begin
                    dacLoad_d     = 1'b1;
                    restorePend_d = 1'b0;
                end
            end

            ST_LOAD: begin
                // LOAD already strobed the DAC, so the restore strobe is deferred a clock.
                if (ABORT) begin
                    state_d       = ST_IDLE;
                    dacCode_d     = trim_q;
                    restorePend_d = 1'b1;
                end else begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            end

            ST_SETTLE: begin
                if (ABORT) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    dacCode_d = trim_q;
                    dacLoad_d = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SAMPLE: begin
                if (ABORT) begin
                    state_d   = ST_IDLE;
                    dacCode_d = trim_q;
                    dacLoad_d = 1'b1;
                end else begin
                    work_d = keptWork;
                    if (bitIdx_q == '0) begin
                        state_d   = ST_FINISH;
                        dacCode_d = keptWork;
                        dacLoad_d = 1'b1;
                        done_d    = 1'b1;
                        trim_d    = keptWork;
                        valid_d   = 1'b1;
                        sat_d     = (keptWork == '0) || (keptWork == '1);
                    end else begin
                        state_d   = ST_LOAD;
                        bitIdx_d  = bitIdx_q - 1'b1;
                        dacCode_d = keptWork | nextMask;
                        dacLoad_d = 1'b1;
                    end
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q       <= ST_IDLE;
            work_q        <= '0;
            bitIdx_q      <= '0;
            cnt_q         <= '0;
            restorePend_q <= 1'b0;
            dacCode_q     <= MIDSCALE;
            dacLoad_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            trim_q        <= MIDSCALE;
            valid_q       <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            bitIdx_q      <= bitIdx_d;
            cnt_q         <= cnt_d;
            restorePend_q <= restorePend_d;
            dacCode_q     <= dacCode_d;
            dacLoad_q     <= dacLoad_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            trim_q        <= trim_d;
            valid_q       <= valid_d;
            sat_q         <= sat_d;
        end
    end

    assign DAC_CODE  = dacCode_q;
    assign DAC_LOAD  = dacLoad_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign TRIM      = trim_q;
    assign VALID     = valid_q;
    assign SATURATED = sat_q;

endmodule

// File: tb/tb_opamp_trim_sar.sv
// Directed bench for opamp_trim_sar at DAC_BITS=8, SETTLE_CYC=16 with a behavioural comparator.
module tb_opamp_trim_sar;

    logic       CLK;
    logic       RESET_N;
    logic       START;
    logic       ABORT;
    logic       cmp;
    logic [7:0] DAC_CODE;
    logic       DAC_LOAD;
    logic       BUSY;
    logic       DONE;
    logic [7:0] TRIM;
    logic       VALID;
    logic       SATURATED;

    logic [7:0] target;
    logic       stuckLow;

    int total = 0;
    int bad   = 0;
    int loadCnt = 0;
    int doneCnt = 0;
    int consecLoads = 0;
    logic prevLoad = 1'b0;

    opamp_trim_sar #(
        .DAC_BITS   (8),
        .SETTLE_CYC (16)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .START     (START),
        .ABORT     (ABORT),
        .CMP       (cmp),
        .DAC_CODE  (DAC_CODE),
        .DAC_LOAD  (DAC_LOAD),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .TRIM      (TRIM),
        .VALID     (VALID),
        .SATURATED (SATURATED)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Comparator trips as soon as the DAC code reaches or passes below the hidden offset target.
    assign cmp = stuckLow ? 1'b0 : (DAC_CODE <= target);

    always @(posedge CLK) begin
        #1;
        if (DAC_LOAD) loadCnt++;
        if (DONE) doneCnt++;
        if (DAC_LOAD && prevLoad) consecLoads++;
        prevLoad = DAC_LOAD;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge CLK);
        #3;
    endtask

    // Pulses START for one edge; returns 3ns after that edge (edge 0 of the search).
    task automatic applyStimulus(input logic [7:0] tgt);
        @(negedge CLK);
        target  = tgt;
        loadCnt = 0;
        doneCnt = 0;
        START   = 1'b1;
        @(posedge CLK);
        #3;
        START = 1'b0;
    endtask

    initial begin
        RESET_N  = 1'b0;
        START    = 1'b0;
        ABORT    = 1'b0;
        target   = 8'h00;
        stuckLow = 1'b0;

        #12;
        checkOutput("rst_dac_code", DAC_CODE, 8'h80);
        checkOutput("rst_trim", TRIM, 8'h80);
        checkOutput("rst_dac_load", DAC_LOAD, 1'b0);
        checkOutput("rst_busy", BUSY, 1'b0);
        checkOutput("rst_done", DONE, 1'b0);
        checkOutput("rst_valid", VALID, 1'b0);
        checkOutput("rst_sat", SATURATED, 1'b0);
        @(negedge CLK);
        RESET_N = 1'b1;
        waitEdges(3);

        $display("[TB] search for target 0x5A");
        applyStimulus(8'h5A);
        checkOutput("first_load_code", DAC_CODE, 8'h80);
        checkOutput("first_load_strobe", DAC_LOAD, 1'b1);
        checkOutput("first_busy", BUSY, 1'b1);
        waitEdges(17);
        checkOutput("sample_no_strobe", DAC_LOAD, 1'b0);
        waitEdges(1);
        checkOutput("bit6_trial_code", DAC_CODE, 8'h40);
        waitEdges(125);
        checkOutput("done_not_early", DONE, 1'b0);
        checkOutput("busy_before_finish", BUSY, 1'b1);
        waitEdges(1);
        checkOutput("done_at_145", DONE, 1'b1);
        checkOutput("trim_5a", TRIM, 8'h5A);
        checkOutput("final_code_5a", DAC_CODE, 8'h5A);
        checkOutput("valid_5a", VALID, 1'b1);
        checkOutput("sat_5a", SATURATED, 1'b0);
        checkOutput("load_pulses_5a", loadCnt, 9);
        waitEdges(1);
        checkOutput("done_one_clock", DONE, 1'b0);
        checkOutput("busy_after_finish", BUSY, 1'b0);
        checkOutput("done_count_5a", doneCnt, 1);

        $display("[TB] abort at clock 60");
        applyStimulus(8'h33);
        waitEdges(59);
        checkOutput("bit4_trial_code", DAC_CODE, 8'h30);
        loadCnt = 0;
        ABORT   = 1'b1;
        waitEdges(1);
        ABORT = 1'b0;
        checkOutput("abort_busy", BUSY, 1'b0);
        checkOutput("abort_restore_code", DAC_CODE, 8'h5A);
        checkOutput("abort_restore_strobe", DAC_LOAD, 1'b1);
        waitEdges(20);
        checkOutput("abort_load_count", loadCnt, 1);
        checkOutput("abort_no_done", doneCnt, 0);
        checkOutput("abort_trim", TRIM, 8'h5A);
        checkOutput("abort_valid", VALID, 1'b1);

        $display("[TB] target 0xFF with stray START pulses");
        applyStimulus(8'hFF);
        waitEdges(9);
        START = 1'b1;
        waitEdges(1);
        START = 1'b0;
        waitEdges(89);
        START = 1'b1;
        waitEdges(1);
        START = 1'b0;
        checkOutput("busy_mid_run", BUSY, 1'b1);
        waitEdges(43);
        checkOutput("ff_done_not_early", DONE, 1'b0);
        waitEdges(1);
        checkOutput("ff_done_at_145", DONE, 1'b1);
        checkOutput("trim_ff", TRIM, 8'hFF);
        checkOutput("sat_ff", SATURATED, 1'b1);
        waitEdges(4);
        checkOutput("ff_single_done", doneCnt, 1);
        checkOutput("ff_idle_after", BUSY, 1'b0);

        $display("[TB] comparator stuck low");
        stuckLow = 1'b1;
        applyStimulus(8'h5A);
        waitEdges(144);
        checkOutput("stuck_done", DONE, 1'b1);
        checkOutput("trim_00", TRIM, 8'h00);
        checkOutput("code_00", DAC_CODE, 8'h00);
        checkOutput("sat_00", SATURATED, 1'b1);
        waitEdges(2);
        stuckLow = 1'b0;

        $display("[TB] ABORT overrides START in IDLE");
        @(negedge CLK);
        loadCnt = 0;
        START   = 1'b1;
        ABORT   = 1'b1;
        @(posedge CLK);
        #3;
        START = 1'b0;
        ABORT = 1'b0;
        checkOutput("idle_abort_busy", BUSY, 1'b0);
        waitEdges(2);
        checkOutput("idle_abort_loads", loadCnt, 0);

        $display("[TB] reset at clock 70");
        applyStimulus(8'h5A);
        waitEdges(69);
        RESET_N = 1'b0;
        #1;
        checkOutput("mid_rst_code", DAC_CODE, 8'h80);
        checkOutput("mid_rst_trim", TRIM, 8'h80);
        checkOutput("mid_rst_load", DAC_LOAD, 1'b0);
        checkOutput("mid_rst_busy", BUSY, 1'b0);
        checkOutput("mid_rst_valid", VALID, 1'b0);
        checkOutput("mid_rst_sat", SATURATED, 1'b0);
        waitEdges(3);
        @(negedge CLK);
        RESET_N = 1'b1;
        doneCnt = 0;
        waitEdges(200);
        checkOutput("no_done_after_rst", doneCnt, 0);
        checkOutput("idle_after_rst", BUSY, 1'b0);

        applyStimulus(8'hA5);
        waitEdges(144);
        checkOutput("post_rst_done", DONE, 1'b1);
        checkOutput("post_rst_trim", TRIM, 8'hA5);
        checkOutput("post_rst_valid", VALID, 1'b1);
        checkOutput("post_rst_sat", SATURATED, 1'b0);
        waitEdges(2);

        checkOutput("no_back_to_back_load", consecLoads, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opamp_trim_sar.md
OPAMP_TRIM_SAR -- requirements
Module: opamp_trim_sar

Interface
REQ-001 SHALL have parameter DAC_BITS, default 8: width of the trim DAC code.
REQ-002 SHALL have parameter SETTLE_CYC, default 16, legal range 2..255: clocks waited after each DAC load before sampling.
REQ-003 SHALL have port CLK, input, 1 bit: the only clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port START, input, 1 bit: request a trim search; sampled only in IDLE.
REQ-006 SHALL have port ABORT, input, 1 bit: cancel a search in progress.
REQ-007 SHALL have port CMP, input, 1 bit: precision op-amp/comparator output, asynchronous to CLK; 1 = keep trial bit.
REQ-008 SHALL have port DAC_CODE, output, DAC_BITS: code presented to the trim DAC.
REQ-009 SHALL have port DAC_LOAD, output, 1 bit: one-clock strobe, DAC latches DAC_CODE.
REQ-010 SHALL have port BUSY, output, 1 bit: high from LOAD of the first bit through FINISH.
REQ-011 SHALL have port DONE, output, 1 bit: one-clock pulse at successful completion.
REQ-012 SHALL have port TRIM, output, DAC_BITS: last completed trim result.
REQ-013 SHALL have port VALID, output, 1 bit: TRIM holds a completed result.
REQ-014 SHALL have port SATURATED, output, 1 bit: last result all-zeros or all-ones.

Function
REQ-015 SHALL pass CMP through a two-flop synchronizer before use; the raw CMP SHALL drive no other logic.
REQ-016 SHALL implement states IDLE, LOAD, SETTLE, SAMPLE, FINISH.
REQ-017 IDLE: START=1 and ABORT=0 -> LOAD with bit index = DAC_BITS-1 and working code cleared; otherwise stay.
REQ-018 LOAD (1 clock): DAC_CODE = working code with the current bit set; DAC_LOAD=1; -> SETTLE.
REQ-019 SETTLE: count exactly SETTLE_CYC clocks, DAC_CODE held; -> SAMPLE.
REQ-020 SAMPLE (1 clock): synchronized CMP=1 keeps the current bit, CMP=0 clears it; bit index 0 -> FINISH, else decrement index and -> LOAD.
REQ-021 FINISH (1 clock): DAC_CODE=TRIM=final code; DAC_LOAD=1; DONE=1; VALID=1; SATURATED updated; -> IDLE.
REQ-022 Latency: DONE SHALL be high in the clock DAC_BITS*(SETTLE_CYC+2)+1 after the edge that samples START (145 at defaults).
REQ-023 START while not IDLE SHALL be ignored, not queued.
REQ-024 ABORT in LOAD/SETTLE/SAMPLE SHALL go to IDLE on the next edge, restore DAC_CODE to TRIM with one DAC_LOAD pulse, and leave TRIM/VALID/SATURATED unchanged; no DONE.
REQ-025 ABORT in FINISH SHALL be ignored (completion wins); ABORT in IDLE has no effect and overrides a simultaneous START.
REQ-026 DAC_LOAD SHALL never be high on two consecutive clocks except LOAD immediately following SAMPLE.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 RESET_N low SHALL immediately force: state IDLE, DAC_CODE and TRIM = midscale (MSB only set, 0x80 at default), DAC_LOAD=0, BUSY=0, DONE=0, VALID=0, SATURATED=0, synchronizer flops 0, counters 0.
REQ-029 Reset mid-search SHALL discard the search with no DONE after release; first START after release starts a fresh search.

Structure
REQ-030 A shared package opamp_trim_pkg SHALL hold the state encoding and default DAC_BITS/SETTLE_CYC constants.
REQ-031 The synchronizer SHALL be a separate sub-module sync2 (two flops, async active-low reset).

Verification (DAC_BITS=8, SETTLE_CYC=16; model CMP = (DAC_CODE <= target), applied asynchronously)
REQ-032 Target 0x5A, START pulse -> exactly 9 DAC_LOAD pulses, DONE at clock 145, TRIM=0x5A, VALID=1, SATURATED=0.
REQ-033 Target 0xFF -> TRIM=0xFF, SATURATED=1; CMP stuck 0 -> TRIM=0x00, SATURATED=1.
REQ-034 ABORT at clock 60 after a completed 0x5A run -> BUSY low next clock, DAC_CODE=0x5A with one DAC_LOAD, no DONE, TRIM=0x5A, VALID=1.
REQ-035 START re-pulsed at clocks 10 and 100 of a run -> ignored; single DONE at 145.
REQ-036 RESET_N low at clock 70 -> all outputs at REQ-028 values immediately; no DONE after release; next START completes normally.
